// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - UART RX packet framer: SOF/LEN/payload/XOR-check with cut-through FIFO push
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SOF      = 8'hAA,
    parameter int         MAX_LEN  = 8,
    parameter int         TO_TICKS = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       fifo_full,
    output logic       fifo_push,
    output logic [7:0] fifo_wdata,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    localparam logic [9:0] TO_LAST   = 10'(TO_TICKS - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [1:0] E_LEN     = 2'd0;
    localparam logic [1:0] E_CHK     = 2'd1;
    localparam logic [1:0] E_TO      = 2'd2;
    localparam logic [1:0] E_OVF     = 2'd3;

    state_t     state_q;
    logic [7:0] rem_q;
    logic [7:0] acc_q;
    logic [9:0] to_cnt_q;
    logic       silent_q;
    logic       push_q;
    logic       done_q;
    logic       err_q;
    logic       busy_q;
    logic [7:0] wdata_q;
    logic [1:0] code_q;
    logic [7:0] rem_d;

    assign rem_d = rem_q - 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rem_q    <= 8'd0;
            acc_q    <= 8'd0;
            to_cnt_q <= 10'd0;
            silent_q <= 1'b0;
            push_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            wdata_q  <= 8'd0;
            code_q   <= 2'd0;
        end else begin
            push_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // A received byte always takes precedence over a coincident timeout tick.
            if (rx_done) begin
                to_cnt_q <= 10'd0;
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_data == SOF) begin
                            state_q <= S_LEN;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            err_q   <= 1'b1;
                            code_q  <= E_LEN;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            rem_q    <= rx_data;
                            acc_q    <= rx_data;
                            silent_q <= 1'b0;
                            state_q  <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        acc_q <= acc_q ^ rx_data;
                        rem_q <= rem_d;
                        if (fifo_full) begin
                            err_q    <= 1'b1;
                            code_q   <= E_OVF;
                            silent_q <= 1'b1;
                            state_q  <= (rem_d != 8'd0) ? S_DRAIN : S_CHK;
                        end else begin
                            push_q  <= 1'b1;
                            wdata_q <= rx_data;
                            if (rem_d == 8'd0) begin
                                state_q <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (!silent_q) begin
                            if (rx_data == acc_q) begin
                                done_q <= 1'b1;
                            end else begin
                                err_q  <= 1'b1;
                                code_q <= E_CHK;
                            end
                        end
                        silent_q <= 1'b0;
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                    end
                    S_DRAIN: begin
                        // rem_q counts payload bytes still to skip; the byte seen at zero is the CHK byte.
                        if (rem_q == 8'd0) begin
                            silent_q <= 1'b0;
                            state_q  <= S_IDLE;
                            busy_q   <= 1'b0;
                        end else begin
                            rem_q <= rem_d;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else if (b_tick && state_q != S_IDLE) begin
                if (to_cnt_q == TO_LAST) begin
                    to_cnt_q <= 10'd0;
                    silent_q <= 1'b0;
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    if (state_q != S_DRAIN) begin
                        err_q  <= 1'b1;
                        code_q <= E_TO;
                    end
                end else begin
                    to_cnt_q <= to_cnt_q + 10'd1;
                end
            end
        end
    end

    assign fifo_push  = push_q;
    assign fifo_wdata = wdata_q;
    assign pkt_done   = done_q;
    assign pkt_err    = err_q;
    assign err_code   = code_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb/tb_uart_rx_pkt_ctrl.sv - scoreboard bench for uart_rx_pkt_ctrl with frame-level reference model
module tb_uart_rx_pkt_ctrl;

    localparam logic [7:0] SOF      = 8'hAA;
    localparam int         MAX_LEN  = 8;
    localparam int         TO_TICKS = 480;
    localparam int         K_PUSH   = 0;
    localparam int         K_DONE   = 1;
    localparam int         K_ERR    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b_tick = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_done = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_push;
    logic [7:0] fifo_wdata;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_pkt_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .b_tick    (b_tick),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_wdata(fifo_wdata),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errs   = 0;

    // Reference model: frame-level view, checksum folded over the stored payload at CHK time.
    int         ph = 0;
    int         mlen = 0;
    int         skip = 0;
    int         ticks = 0;
    bit         silent = 0;
    logic [7:0] pay[$];
    logic [1:0] m_code = 2'd0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_ev(int kind, logic [7:0] v);
        exp_q.push_back('{kind, v, cyc + 1});
    endtask

    task automatic expect_err(logic [1:0] code);
        expect_ev(K_ERR, {6'd0, code});
        m_code = code;
    endtask

    task automatic model(bit done, logic [7:0] d, bit tick, bit full);
        logic [7:0] sum;
        if (done) begin
            ticks = 0;
            case (ph)
                0: if (d == SOF) ph = 1;
                1: begin
                    if (d == 8'd0 || int'(d) > MAX_LEN) begin
                        expect_err(2'd0);
                        ph = 0;
                    end else begin
                        mlen = int'(d);
                        pay.delete();
                        ph = 2;
                    end
                end
                2: begin
                    pay.push_back(d);
                    if (full) begin
                        expect_err(2'd3);
                        if (pay.size() < mlen) begin
                            skip = mlen - pay.size() + 1;
                            ph = 4;
                        end else begin
                            silent = 1;
                            ph = 3;
                        end
                    end else begin
                        expect_ev(K_PUSH, d);
                        if (pay.size() == mlen) begin
                            silent = 0;
                            ph = 3;
                        end
                    end
                end
                3: begin
                    if (!silent) begin
                        sum = 8'(mlen);
                        foreach (pay[i]) sum ^= pay[i];
                        if (d == sum) expect_ev(K_DONE, 8'd0);
                        else expect_err(2'd1);
                    end
                    ph = 0;
                end
                default: begin
                    skip--;
                    if (skip == 0) ph = 0;
                end
            endcase
        end else if (tick && ph != 0) begin
            ticks++;
            if (ticks == TO_TICKS) begin
                if (ph != 4) expect_err(2'd2);
                ph = 0;
                ticks = 0;
            end
        end
    endtask

    task automatic step(bit done, logic [7:0] d, bit tick, bit full);
        rx_done   = done;
        rx_data   = d;
        b_tick    = tick;
        fifo_full = full;
        model(done, d, tick, full);
        @(posedge clk);
        #1;
        rx_done   = 1'b0;
        b_tick    = 1'b0;
        fifo_full = 1'b0;
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("err_code_hold", 32'(err_code), 32'(m_code));
    endtask

    task automatic send(logic [7:0] d, bit full = 1'b0);
        step(1'b1, d, 1'b0, full);
    endtask

    task automatic rsend(logic [7:0] d);
        repeat ($urandom_range(0, 3)) step(1'b0, 8'd0, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
        step(1'b1, d, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
    endtask

    task automatic ticks_only(int n);
        repeat (n) step(1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic mon_out(int kind, logic [7:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL unexpected_output: kind=%0d val=%0h at cycle %0d, nothing expected", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.at != cyc) begin
                n_errs++;
                $display("FAIL output_event: got kind=%0d val=%0h cycle=%0d expected kind=%0d val=%0h cycle=%0d",
                         kind, val, cyc, e.kind, e.val, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (fifo_push) mon_out(K_PUSH, fifo_wdata);
            if (pkt_done)  mon_out(K_DONE, 8'd0);
            if (pkt_err)   mon_out(K_ERR, {6'd0, err_code});
        end
    end

    task automatic check_all_zero(string tag);
        chk({tag, "_fifo_push"}, 32'(fifo_push), 32'd0);
        chk({tag, "_fifo_wdata"}, 32'(fifo_wdata), 32'd0);
        chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        chk({tag, "_pkt_err"}, 32'(pkt_err), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Good frame
        send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        // Bad checksum, then a good one-byte frame
        send(8'hAA); send(8'h02); send(8'h55); send(8'h66); send(8'h00);
        send(8'hAA); send(8'h01); send(8'h7E); send(8'h7F);
        // Noise and bad LEN values
        send(8'h12); send(8'h34); send(8'hAA); send(8'h00);
        send(8'hAA); send(8'h09);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        // Overflow with a SOF-valued payload byte drained silently
        send(8'hAA); send(8'h04); send(8'hA1); send(8'hA2, 1'b1); send(8'hAA); send(8'hA4); send(8'h5C);
        // Overflow on the last payload byte: CHK consumed silently
        send(8'hAA); send(8'h02); send(8'hB1); send(8'hB2, 1'b1); send(8'h00);
        // Timeout mid-payload
        send(8'hAA); send(8'h03); send(8'h11);
        ticks_only(TO_TICKS);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        // rx_done coinciding with the 480th tick wins
        send(8'hAA); send(8'h03); send(8'h11);
        ticks_only(TO_TICKS - 1);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        send(8'h33); send(8'h03);
        // Timeout while draining is silent
        send(8'hAA); send(8'h04); send(8'hA1); send(8'hA2, 1'b1);
        ticks_only(TO_TICKS);
        step(1'b0, 8'd0, 1'b0, 1'b0);

        // Async reset in PAYLOAD right after a push
        send(8'hAA); send(8'h03); send(8'h11);
        #5;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        chk("queue_after_reset", 32'(exp_q.size()), 32'd0);
        ph = 0; ticks = 0; m_code = 2'd0; silent = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h01);
        step(1'b0, 8'd0, 1'b0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 150; f++) begin
            int         kind;
            int         len;
            logic [7:0] x;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                rsend(8'($urandom_range(0, 255)));
            end else begin
                rsend(SOF);
                if (kind == 1) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                else len = $urandom_range(1, MAX_LEN);
                rsend(8'(len));
                if (kind != 1) begin
                    x = 8'(len);
                    for (int i = 0; i < len; i++) begin
                        b = 8'($urandom_range(0, 255));
                        if (i == 0 && kind == 2) b = SOF;
                        x ^= b;
                        rsend(b);
                    end
                    if (kind == 3) x ^= 8'($urandom_range(1, 255));
                    rsend(x);
                end
            end
        end
        ticks_only(TO_TICKS + 2);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
